// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control unit.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational control decode: state plus MemReady/Zero to datapath controls.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t State,
    input  logic   Reset,
    input  logic   MemReady,
    input  logic   Zero,
    output ctrl_t  ctrl
);

    state_t dec_state;

    // While in reset the datapath sees FETCH settings so the PC mux and ALU are quiet.
    assign dec_state = Reset ? FETCH : State;

    always_comb begin
        // NOTE: every field gets a default first so no path through the case infers a latch.
        ctrl = '0;
        case (dec_state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = MemReady;
                ctrl.pc_write  = MemReady;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_write  = Zero;
            end
            JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            default: ctrl = '0;
        endcase

        if (Reset) begin
            ctrl.pc_write  = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS main control: state register, next-state logic, sticky IllegalOp.
module mips_control_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] State,
    output logic       IllegalOp
);

    state_t state;
    state_t next_state;
    logic   set_illegal;
    ctrl_t  ctrl;

    always_comb begin
        next_state  = FETCH;
        set_illegal = 1'b0;
        case (state)
            FETCH:     next_state = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_RTYPE:     next_state = R_EXEC;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    default:      set_illegal = 1'b1;
                endcase
            end
            MEM_ADDR: begin
                if (Op == OP_LW)      next_state = MEM_READ;
                else if (Op == OP_SW) next_state = MEM_WRITE;
            end
            MEM_READ:  next_state = MemReady ? MEM_WB : MEM_READ;
            MEM_WRITE: next_state = MemReady ? FETCH : MEM_WRITE;
            R_EXEC:    next_state = R_WB;
            default:   next_state = FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= FETCH;
            IllegalOp <= 1'b0;
        end else begin
            state <= next_state;
            if (set_illegal) IllegalOp <= 1'b1;
        end
    end

    mips_ctrl_decode u_decode (
        .State    (state),
        .Reset    (Reset),
        .MemReady (MemReady),
        .Zero     (Zero),
        .ctrl     (ctrl)
    );

    assign State    = state;
    assign PCWrite  = ctrl.pc_write;
    assign PCSource = ctrl.pc_source;
    assign IorD     = ctrl.i_or_d;
    assign MemRead  = ctrl.mem_read;
    assign MemWrite = ctrl.mem_write;
    assign IRWrite  = ctrl.ir_write;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegDst   = ctrl.reg_dst;
    assign RegWrite = ctrl.reg_write;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Scoreboard bench for mips_control_fsm: scripted state sequences, expected outputs per cycle.
module tb_mips_control_fsm;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic [3:0] State;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       iord, mrd, mwr, irw, m2r, rdst, rwr, asa;
        logic [1:0] asb, aop;
        logic       ill;
    } obs_t;

    typedef struct {
        obs_t o;
        logic rst;
        int   id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_id = 0;
    logic exp_illegal = 1'b0;

    always #5 CLK = ~CLK;

    mips_control_fsm dut (
        .CLK(CLK), .Reset(Reset), .Op(Op), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .State(State), .IllegalOp(IllegalOp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs for a state, straight from the control table.
    function automatic obs_t model(input logic [3:0] st, input logic mr, input logic z);
        obs_t o = '0;
        o.st = st;
        case (st)
            4'd0: begin o.mrd = 1; o.asb = 2'b01; o.irw = mr; o.pcw = mr; end
            4'd1: o.asb = 2'b11;
            4'd2: begin o.asa = 1; o.asb = 2'b10; end
            4'd3: begin o.mrd = 1; o.iord = 1; end
            4'd4: begin o.rwr = 1; o.m2r = 1; end
            4'd5: begin o.mwr = 1; o.iord = 1; end
            4'd6: begin o.asa = 1; o.aop = 2'b10; end
            4'd7: begin o.rwr = 1; o.rdst = 1; end
            4'd8: begin o.asa = 1; o.aop = 2'b01; o.pcs = 2'b01; o.pcw = z; end
            4'd9: begin o.pcs = 2'b10; o.pcw = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // One clock: drive inputs, push the expectation, advance past the edge.
    task automatic cyc(input logic [3:0] st, input logic mr, input logic z, input logic rst);
        exp_t e;
        MemReady = mr;
        Zero     = z;
        Reset    = rst;
        e.o      = model(st, mr, z);
        e.o.ill  = exp_illegal;
        e.rst    = rst;
        e.id     = cyc_id++;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (rst) exp_illegal = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            obs_t a;
            string p;
            e = sb.pop_front();
            a = '{State, PCWrite, PCSource, IorD, MemRead, MemWrite, IRWrite,
                  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, IllegalOp};
            p = $sformatf("c%0d_s%0d", e.id, e.o.st);
            check({p, "_State"},     32'(a.st),  32'(e.o.st));
            check({p, "_PCWrite"},   32'(a.pcw), 32'(e.o.pcw));
            check({p, "_IRWrite"},   32'(a.irw), 32'(e.o.irw));
            check({p, "_MemRead"},   32'(a.mrd), 32'(e.o.mrd & ~e.rst));
            check({p, "_MemWrite"},  32'(a.mwr), 32'(e.o.mwr & ~e.rst));
            check({p, "_RegWrite"},  32'(a.rwr), 32'(e.o.rwr & ~e.rst));
            check({p, "_IllegalOp"}, 32'(a.ill), 32'(e.o.ill));
            if (!e.rst) begin
                check({p, "_PCSource"}, 32'(a.pcs),  32'(e.o.pcs));
                check({p, "_IorD"},     32'(a.iord), 32'(e.o.iord));
                check({p, "_MemtoReg"}, 32'(a.m2r),  32'(e.o.m2r));
                check({p, "_RegDst"},   32'(a.rdst), 32'(e.o.rdst));
                check({p, "_ALUSrcA"},  32'(a.asa),  32'(e.o.asa));
                check({p, "_ALUSrcB"},  32'(a.asb),  32'(e.o.asb));
                check({p, "_ALUOp"},    32'(a.aop),  32'(e.o.aop));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1; Op = 6'b000000; Zero = 1'b0; MemReady = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // lw, no stalls: 0,1,2,3,4
        Op = 6'b100011;
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(2, 1, 0, 0); cyc(3, 1, 0, 0); cyc(4, 1, 0, 0);

        // sw, MEM_WRITE held three cycles
        Op = 6'b101011;
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(2, 1, 0, 0);
        cyc(5, 0, 0, 0); cyc(5, 0, 0, 0); cyc(5, 0, 0, 0); cyc(5, 1, 0, 0);

        // R-type with one FETCH stall
        Op = 6'b000000;
        cyc(0, 0, 0, 0); cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(6, 1, 0, 0); cyc(7, 1, 0, 0);

        // beq taken then not taken
        Op = 6'b000100;
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(8, 1, 1, 0);
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(8, 1, 0, 0);

        // j
        Op = 6'b000010;
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(9, 1, 0, 0);

        // lw with one MEM_READ stall
        Op = 6'b100011;
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(2, 1, 0, 0);
        cyc(3, 0, 0, 0); cyc(3, 1, 0, 0); cyc(4, 1, 0, 0);

        // illegal opcode, then sticky through an R-type
        Op = 6'b111111;
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0);
        exp_illegal = 1'b1;
        Op = 6'b000000;
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(6, 1, 0, 0); cyc(7, 1, 0, 0);

        // Reset in the middle of a stalled MEM_WRITE
        Op = 6'b101011;
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(2, 1, 0, 0); cyc(5, 0, 0, 0);
        cyc(5, 0, 0, 1);
        Op = 6'b000010;
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(9, 1, 0, 0);

        @(posedge CLK);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
